// File: rtl/thcattus_uart_pkg.sv
// Shared constants for the thcattus UART receiver: parity modes, FSM state
// encoding, sideband (tuser) bit positions and the parity helper.
package thcattus_uart_pkg;

  localparam int PAR_NONE = 0;
  localparam int PAR_ODD  = 1;
  localparam int PAR_EVEN = 2;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } uart_state_e;

  localparam int TUSER_PAR = 0;
  localparam int TUSER_FRM = 1;
  localparam int TUSER_OVR = 2;

  // Parity bit a correct transmitter sends for this data byte.
  function automatic logic parity_bit(input int mode, input logic [7:0] d);
    return (mode == PAR_ODD) ? ~^d : ^d;
  endfunction

endpackage

// File: rtl/thcattus_uart_rx2_if.sv
// AXI-Stream style output bundle of the UART receiver.
// Handshake: a word transfers on a clock edge where axis_tvalid and
// axis_tready are both high; while axis_tvalid is high and axis_tready is low
// the master keeps tdata/tkeep/tlast/tuser stable. The master never waits
// for axis_tready before raising axis_tvalid.
interface thcattus_uart_rx2_if #(
  parameter int DATA_WIDTH = 4
);
  import thcattus_uart_pkg::*;

  logic                    axis_tvalid;
  logic                    axis_tready;
  logic [DATA_WIDTH*8-1:0] axis_tdata;
  logic [DATA_WIDTH-1:0]   axis_tkeep;
  logic                    axis_tlast;
  logic [2:0]              axis_tuser;

  modport master (
    output axis_tvalid, axis_tdata, axis_tkeep, axis_tlast, axis_tuser,
    input  axis_tready
  );

  modport slave (
    input  axis_tvalid, axis_tdata, axis_tkeep, axis_tlast, axis_tuser,
    output axis_tready
  );

endinterface

// File: rtl/thcattus_uart_baud_tick.sv
// Oversampling tick generator: one-cycle tick every DIV clocks. A restart
// zeroes the phase so the first tick lands DIV clocks after the start edge.
module thcattus_uart_baud_tick
  import thcattus_uart_pkg::*;
#(
  parameter int DIV = 2
) (
  input  logic axis_aclk,
  input  logic axis_arestn,
  input  logic restart,
  output logic tick
);

  localparam int CW = (DIV > 2) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DIV - 1);

  logic [CW-1:0] cnt;

  // Phase counter, wraps at DIV-1 or restarts on a start edge.
  always_ff @(posedge axis_aclk or negedge axis_arestn) begin
    if (!axis_arestn)                   cnt <= '0;
    else if (restart || cnt == CNT_MAX) cnt <= '0;
    else                                cnt <= cnt + 1'b1;
  end

  assign tick = !restart && (cnt == CNT_MAX);

endmodule

// File: rtl/thcattus_uart_rx2.sv
// UART receiver packing bytes into DATA_WIDTH-byte stream words with
// per-word error flags, idle-timeout flushing and overrun reporting.
module thcattus_uart_rx2
  import thcattus_uart_pkg::*;
#(
  parameter int DATA_WIDTH   = 4,
  parameter int CLOCK_FREQ   = 50_000_000,
  parameter int BAUD_RATE    = 115200,
  parameter int OVERSAMPLE   = 16,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1,
  parameter int IDLE_TIMEOUT = 0
) (
  input  logic                       axis_aclk,
  input  logic                       axis_arestn,
  input  logic                       uart_rx,
  thcattus_uart_rx2_if.master        m_axis,
  output uart_state_e                dbg_state
);

  localparam int DIV = CLOCK_FREQ / (BAUD_RATE * OVERSAMPLE);
  localparam int SW  = $clog2(OVERSAMPLE);
  localparam int AW  = $clog2(DATA_WIDTH + 1);
  localparam logic [SW-1:0] S_EARLY  = SW'(OVERSAMPLE / 2 - 1);
  localparam logic [SW-1:0] S_CENTER = SW'(OVERSAMPLE / 2);
  localparam logic [SW-1:0] S_MID    = SW'(OVERSAMPLE / 2 + 1);
  localparam logic [SW-1:0] S_LAST   = SW'(OVERSAMPLE - 1);
  localparam logic          STOP_LAST = 1'(STOP_BITS - 1);
  localparam logic [AW-1:0] FULL     = AW'(DATA_WIDTH);
  localparam logic [31:0]   IDLE_TO  = 32'(IDLE_TIMEOUT);
  localparam logic          TO_EN    = (IDLE_TIMEOUT > 0);

  if (DIV < 2) begin : g_bad_div
    $error("thcattus_uart_rx2: CLOCK_FREQ/(BAUD_RATE*OVERSAMPLE) must be at least 2");
  end

  uart_state_e   state, state_d;
  logic [1:0]    rx_sync;
  logic          rx_d, rx_s, fall, restart, tick, maj, byte_done, frm_now;
  logic [SW-1:0] s_cnt;
  logic [1:0]    samp;
  logic [7:0]    shreg;
  logic [2:0]    bit_cnt;
  logic          stop_cnt, par_err, frm_err;
  logic [DATA_WIDTH*8-1:0] asm_data;
  logic [AW-1:0] asm_cnt;
  logic          asm_par, asm_frm, ovr_pending;
  logic [31:0]   idle_cnt;
  logic          word_full, flush, xfer, out_free;
  logic [DATA_WIDTH-1:0] keep_n;
  logic [2:0]    tuser_n;

  thcattus_uart_baud_tick #(.DIV(DIV)) u_tick (
    .axis_aclk  (axis_aclk),
    .axis_arestn(axis_arestn),
    .restart    (restart),
    .tick       (tick)
  );

  // Two-flop synchronizer plus one delay flop for falling-edge detection.
  always_ff @(posedge axis_aclk or negedge axis_arestn) begin
    if (!axis_arestn) begin
      rx_sync <= 2'b11;
      rx_d    <= 1'b1;
    end else begin
      rx_sync <= {rx_sync[0], uart_rx};
      rx_d    <= rx_sync[1];
    end
  end

  assign rx_s = rx_sync[1];
  assign fall = rx_d & ~rx_s;
  // Majority of the three centre samples; the third is the live one.
  assign maj  = (samp[1] & samp[0]) | (samp[1] & rx_s) | (samp[0] & rx_s);
  assign frm_now = frm_err | ~maj;

  // State register.
  always_ff @(posedge axis_aclk or negedge axis_arestn) begin
    if (!axis_arestn) state <= ST_IDLE;
    else              state <= state_d;
  end

  // Next state; bits are judged at the centre sample, states advance at bit end
  // except the last stop bit, which releases to IDLE at its centre.
  always_comb begin
    state_d   = state;
    restart   = 1'b0;
    byte_done = 1'b0;
    case (state)
      ST_IDLE: if (fall) begin
        restart = 1'b1;
        state_d = ST_START;
      end
      ST_START: begin
        if (tick && s_cnt == S_MID && maj)  state_d = ST_IDLE;
        else if (tick && s_cnt == S_LAST)   state_d = ST_DATA;
      end
      ST_DATA: if (tick && s_cnt == S_LAST && bit_cnt == 3'd7)
        state_d = (PARITY == PAR_NONE) ? ST_STOP : ST_PARITY;
      ST_PARITY: if (tick && s_cnt == S_LAST) state_d = ST_STOP;
      ST_STOP: if (tick && s_cnt == S_MID && stop_cnt == STOP_LAST) begin
        state_d   = ST_IDLE;
        byte_done = 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Per-frame sampling, shift register and error capture.
  always_ff @(posedge axis_aclk or negedge axis_arestn) begin
    if (!axis_arestn) begin
      s_cnt <= '0; samp <= '0; shreg <= '0; bit_cnt <= '0;
      stop_cnt <= 1'b0; par_err <= 1'b0; frm_err <= 1'b0;
    end else if (restart) begin
      s_cnt <= '0; bit_cnt <= '0;
      stop_cnt <= 1'b0; par_err <= 1'b0; frm_err <= 1'b0;
    end else if (tick) begin
      s_cnt <= s_cnt + 1'b1;
      if (s_cnt == S_EARLY || s_cnt == S_CENTER) samp <= {samp[0], rx_s};
      if (s_cnt == S_MID) begin
        case (state)
          ST_DATA:   shreg <= {maj, shreg[7:1]};
          ST_PARITY: if (maj != parity_bit(PARITY, shreg)) par_err <= 1'b1;
          ST_STOP:   if (!maj) frm_err <= 1'b1;
          default:   ;
        endcase
      end
      if (s_cnt == S_LAST) begin
        if (state == ST_DATA) bit_cnt  <= bit_cnt + 1'b1;
        if (state == ST_STOP) stop_cnt <= stop_cnt + 1'b1;
      end
    end
  end

  assign word_full = (asm_cnt == FULL);
  assign flush     = TO_EN && (idle_cnt == IDLE_TO) && (asm_cnt != '0);
  assign xfer      = word_full || flush;
  assign out_free  = !m_axis.axis_tvalid || m_axis.axis_tready;

  // Idle bit-time counter, saturating; any start edge or transfer clears it.
  always_ff @(posedge axis_aclk or negedge axis_arestn) begin
    if (!axis_arestn)                 idle_cnt <= '0;
    else if (restart || xfer)         idle_cnt <= '0;
    else if (state == ST_IDLE && tick && s_cnt == S_LAST && idle_cnt != IDLE_TO)
      idle_cnt <= idle_cnt + 1'b1;
  end

  // Byte assembler; a transfer empties it whether the word loads or drops.
  always_ff @(posedge axis_aclk or negedge axis_arestn) begin
    if (!axis_arestn) begin
      asm_data <= '0; asm_cnt <= '0; asm_par <= 1'b0; asm_frm <= 1'b0;
      ovr_pending <= 1'b0;
    end else if (xfer) begin
      asm_data <= '0; asm_cnt <= '0; asm_par <= 1'b0; asm_frm <= 1'b0;
      ovr_pending <= !out_free;
    end else if (byte_done) begin
      asm_data[int'(asm_cnt)*8 +: 8] <= shreg;
      asm_cnt <= asm_cnt + 1'b1;
      asm_par <= asm_par | par_err;
      asm_frm <= asm_frm | frm_now;
    end
  end

  // Keep mask for the bytes held and the sideband flags of the word.
  always_comb begin
    keep_n = '0;
    for (int i = 0; i < DATA_WIDTH; i++) keep_n[i] = (AW'(i) < asm_cnt);
    tuser_n = '0;
    tuser_n[TUSER_PAR] = asm_par;
    tuser_n[TUSER_FRM] = asm_frm;
    tuser_n[TUSER_OVR] = ovr_pending;
  end

  // Output register: loads when free or being accepted, else holds.
  always_ff @(posedge axis_aclk or negedge axis_arestn) begin
    if (!axis_arestn) begin
      m_axis.axis_tvalid <= 1'b0;
      m_axis.axis_tdata  <= '0;
      m_axis.axis_tkeep  <= '0;
      m_axis.axis_tlast  <= 1'b0;
      m_axis.axis_tuser  <= '0;
    end else if (xfer && out_free) begin
      m_axis.axis_tvalid <= 1'b1;
      m_axis.axis_tdata  <= asm_data;
      m_axis.axis_tkeep  <= keep_n;
      m_axis.axis_tlast  <= !word_full;
      m_axis.axis_tuser  <= tuser_n;
    end else if (m_axis.axis_tready) begin
      m_axis.axis_tvalid <= 1'b0;
    end
  end

  assign dbg_state = state;

endmodule

// File: doc/thcattus_uart_rx2.md
THCATTUS_UART_RX2 -- requirements
Module: thcattus_uart_rx2

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 4, output word width in bytes (1..8).
REQ-002 SHALL have parameter CLOCK_FREQ, default 50_000_000, axis_aclk frequency in Hz.
REQ-003 SHALL have parameter BAUD_RATE, default 115200, line rate in bit/s.
REQ-004 SHALL have parameter OVERSAMPLE, default 16, samples per bit (8 or 16).
REQ-005 SHALL have parameter PARITY, default 0, parity mode: 0 none, 1 odd, 2 even.
REQ-006 SHALL have parameter STOP_BITS, default 1, stop bits checked (1 or 2).
REQ-007 SHALL have parameter IDLE_TIMEOUT, default 0, idle bit-times before a partial word is flushed; 0 disables flushing.
REQ-008 SHALL have port: axis_aclk  input  1  the only clock.
REQ-009 SHALL have port: axis_arestn  input  1  reset; asynchronous, active-low.
REQ-010 SHALL have port: uart_rx  input  1  asynchronous serial line, idle high.
REQ-011 SHALL have port: axis_tvalid  output  1  output word valid.
REQ-012 SHALL have port: axis_tready  input  1  downstream accept.
REQ-013 SHALL have port: axis_tdata  output  DATA_WIDTH*8  received bytes; first byte in [7:0].
REQ-014 SHALL have port: axis_tkeep  output  DATA_WIDTH  one bit per valid byte, contiguous from bit 0.
REQ-015 SHALL have port: axis_tlast  output  1  high on timeout-flushed words only.
REQ-016 SHALL have port: axis_tuser  output  3  [0] parity error, [1] framing error, [2] overrun, each the OR over the word.

Function
REQ-017 SHALL pass uart_rx through a 2-flop synchronizer before any use.
REQ-018 SHALL generate a one-cycle sample tick every DIV = CLOCK_FREQ/(BAUD_RATE*OVERSAMPLE) clocks; DIV < 2 SHALL be an elaboration error.
REQ-019 SHALL implement states IDLE, START, DATA, PARITY, STOP; PARITY is skipped when PARITY=0.
REQ-020 IDLE->START on a synchronized high-to-low transition; the sample-tick phase counter SHALL restart at that transition.
REQ-021 Each bit value SHALL be the majority of samples OVERSAMPLE/2-1, OVERSAMPLE/2, OVERSAMPLE/2+1.
REQ-022 START with majority 1 SHALL be a false start: return to IDLE, no byte produced, no flag.
REQ-023 DATA SHALL capture 8 bits LSB first.
REQ-024 PARITY SHALL compare the received bit against odd/even parity of the 8 data bits; a mismatch sets the byte's parity flag.
REQ-025 STOP SHALL check STOP_BITS stop bits; any 0 sets the framing flag; the byte is still stored.
REQ-026 SHALL return to IDLE at the mid-point of the last stop bit, permitting back-to-back frames.
REQ-027 Completed bytes SHALL pack into an assembler at byte index 0..DATA_WIDTH-1 and accumulate flags.
REQ-028 A full assembler SHALL transfer to the output register one cycle after the last byte completes, tkeep all ones, tlast 0.
REQ-029 When IDLE_TIMEOUT>0 and the assembler is non-empty, IDLE_TIMEOUT consecutive idle bit-times SHALL flush it with tkeep = low n bits set (n bytes held) and tlast 1.
REQ-030 The idle counter SHALL clear on any start edge.
REQ-031 The output register SHALL hold tdata/tkeep/tlast/tuser stable while tvalid=1 and tready=0.
REQ-032 tvalid SHALL clear on tvalid&tready unless a new word loads in the same cycle, in which case tvalid stays 1 with the new word.
REQ-033 A word ready to transfer while the output register is still occupied and not being accepted SHALL be dropped, the assembler cleared, and overrun set on the next delivered word.
REQ-034 Reception SHALL continue while the output register is full; the line is never stalled.

Reset
REQ-035 On axis_arestn low, all flops SHALL reset asynchronously: state IDLE, assembler empty, counters 0, synchronizer 1s.
REQ-036 Reset SHALL drive axis_tvalid 0, axis_tdata 0, axis_tkeep 0, axis_tlast 0, axis_tuser 0.
REQ-037 Reset asserted mid-frame SHALL discard the partial frame and assembler; after release the first start edge begins a new frame.

Structure
REQ-038 Package thcattus_uart_pkg SHALL hold the parity mode constants, state encodings and tuser bit indices.
REQ-039 Sub-module thcattus_uart_baud_tick SHALL implement the restartable sample-tick divider of REQ-018/020.

Verification (CLOCK_FREQ 16_000_000, BAUD_RATE 500_000, OVERSAMPLE 16, DIV 2, 32 clocks/bit)
REQ-040 DATA_WIDTH 4, bytes 0x11,0x22,0x33,0x44, tready=1 -> one word tdata 0x44332211, tkeep 0xF, tlast 0, tuser 0.
REQ-041 PARITY 2, byte 0xA5 with parity bit 1 -> tuser[0]=1; correct parity bit 0 -> tuser[0]=0.
REQ-042 Stop bit driven 0 on byte 0x5A -> byte stored, tuser[1]=1; a 10-clock low glitch in IDLE -> no byte.
REQ-043 IDLE_TIMEOUT 4, two bytes 0xAB,0xCD then idle -> after 4 bit-times word tdata[15:0]=0xCDAB, tkeep 0x3, tlast 1.
REQ-044 tready=0, send 8 bytes -> first word held, second dropped; raise tready, send 4 bytes -> tuser[2]=1 on that word.
REQ-045 Assert reset during bit 4 of a frame -> all outputs 0; next full frame 0x3C received correctly.
